// File: rtl/packet_arbiter_pkg.sv
// packet_arbiter_pkg
// Shared AXI-Stream types, widths and the routing-header TID used by the
// router merge stage. Also provides the round-robin pointer increment.
package packet_arbiter_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int ID_WIDTH             = 4;
  localparam int DEST_WIDTH           = 4;
  localparam int USER_WIDTH           = 4;
  localparam int CHANNEL_NUMBER       = 5;
  localparam int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER);

  // TID value that marks the first flit of a packet (the XY routing header)
  localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = 4'hF;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] TDATA;
    logic [ID_WIDTH-1:0]   TID;
    logic [DEST_WIDTH-1:0] TDEST;
    logic [USER_WIDTH-1:0] TUSER;
    logic                  TLAST;
  } axis_data_t;

  typedef struct packed {
    axis_data_t data;
    logic       TVALID;
  } axis_mosi_t;

  typedef struct packed {
    logic TREADY;
  } axis_miso_t;

  // Pointer to the input after idx, wrapping CHANNEL_NUMBER-1 -> 0
  function automatic logic [CHANNEL_NUMBER_WIDTH-1:0] rr_next(
    input logic [CHANNEL_NUMBER_WIDTH-1:0] idx
  );
    if (idx == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1))
      return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/packet_arbiter_if.sv
// packet_arbiter_if
// Bundles the candidate input streams and the merged output stream.
//   in_mosi_i  : candidate streams (TVALID + payload)
//   in_miso_o  : TREADY back to each candidate
//   out_mosi_o : merged stream
//   out_miso_i : downstream TREADY
// master: environment side (sources and downstream sink)
// slave : arbiter side
interface packet_arbiter_if;
  import packet_arbiter_pkg::*;

  axis_mosi_t in_mosi_i [CHANNEL_NUMBER];
  axis_miso_t in_miso_o [CHANNEL_NUMBER];
  axis_mosi_t out_mosi_o;
  axis_miso_t out_miso_i;

  modport master (
    output in_mosi_i,
    input  in_miso_o,
    input  out_mosi_o,
    output out_miso_i
  );

  modport slave (
    input  in_mosi_i,
    output in_miso_o,
    output out_mosi_o,
    input  out_miso_i
  );

endinterface

// File: rtl/packet_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin selector: picks the first set request bit
// starting at ptr and searching upward with wrap.
//   req         : request vector
//   ptr         : search start position
//   grant       : one-hot grant
//   grant_idx   : binary index of the granted request
//   grant_valid : at least one request present
module rr_arbiter #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int PTR_WIDTH      = $clog2(CHANNEL_NUMBER)
) (
  input  logic [CHANNEL_NUMBER-1:0] req,
  input  logic [PTR_WIDTH-1:0]      ptr,
  output logic [CHANNEL_NUMBER-1:0] grant,
  output logic [PTR_WIDTH-1:0]      grant_idx,
  output logic                      grant_valid
);

  int cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      cand = (int'(ptr) + k) % CHANNEL_NUMBER;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand[PTR_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// packet_arbiter
// Output-side merge stage of the NoC router. Round-robin arbitration at
// packet granularity: a grant is taken on a routing-header flit and held
// until the TLAST handshake, so packets never interleave. Data and ready
// paths are purely combinational.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : candidate inputs, merged output and their ready signals
//
// state  | meaning
// IDLE   | no packet in flight; header requests arbitrated from rr_ptr
// LOCKED | packet from grant_q in flight until its TLAST handshake
module packet_arbiter
  import packet_arbiter_pkg::*;
(
  input logic             clk_i,
  input logic             rst_n_i,
  packet_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_q, grant_d;

  axis_mosi_t                      in_mosi [CHANNEL_NUMBER];
  axis_miso_t                      in_miso [CHANNEL_NUMBER];
  axis_mosi_t                      out_mosi;
  logic [CHANNEL_NUMBER-1:0]       req;
  logic [CHANNEL_NUMBER-1:0]       arb_grant;
  logic [CHANNEL_NUMBER_WIDTH-1:0] arb_idx;
  logic                            arb_valid;
  logic [CHANNEL_NUMBER-1:0]       sel_onehot;
  logic                            hs;

  for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_port
    assign in_mosi[g]       = bus.in_mosi_i[g];
    assign bus.in_miso_o[g] = in_miso[g];
  end
  assign bus.out_mosi_o = out_mosi;

  // Only header flits compete; data flits at IDLE are left waiting.
  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++)
      req[i] = in_mosi[i].TVALID && (in_mosi[i].data.TID == ROUTING_HEADER);
  end

  rr_arbiter #(
    .CHANNEL_NUMBER (CHANNEL_NUMBER),
    .PTR_WIDTH      (CHANNEL_NUMBER_WIDTH)
  ) u_rr (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign hs = out_mosi.TVALID && bus.out_miso_i.TREADY;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (arb_valid && hs) begin
          rr_ptr_d = rr_next(arb_idx);
          // single-flit packets never lock
          if (!out_mosi.data.TLAST) begin
            state_d = LOCKED;
            grant_d = arb_idx;
          end
        end
      end
      LOCKED: begin
        if (hs && out_mosi.data.TLAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output TVALID comes only from the selected input, never from TREADY.
  always_comb begin
    out_mosi   = '0;
    sel_onehot = '0;
    if (state_q == LOCKED) begin
      out_mosi            = in_mosi[grant_q];
      sel_onehot[grant_q] = 1'b1;
    end else if (arb_valid) begin
      out_mosi   = in_mosi[arb_idx];
      sel_onehot = arb_grant;
    end
    for (int i = 0; i < CHANNEL_NUMBER; i++)
      in_miso[i].TREADY = sel_onehot[i] & bus.out_miso_i.TREADY;
  end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Output-side merge stage of the AXI-Stream NoC router: collects up to CHANNEL_NUMBER input streams, which the per-input XY routing stages have already steered toward this output, onto one output stream. Arbitration is round-robin at packet granularity. A grant is taken on a routing-header flit and held until the TLAST handshake, so packets from different inputs never interleave. One instance sits in front of each router output port, mirroring the per-input routing stage.

## Interface
- DATA_WIDTH, 32, TDATA width carried in axis_mosi_t
- ID_WIDTH, 4, TID width
- DEST_WIDTH, 4, TDEST width
- USER_WIDTH, 4, TUSER width
- CHANNEL_NUMBER, 5, number of competing input streams
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), width of grant index and pointer

Ports:
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- in_mosi_i  in  axis_mosi_t [CHANNEL_NUMBER]  candidate streams
- in_miso_o  out  axis_miso_t [CHANNEL_NUMBER]  TREADY back to each candidate
- out_mosi_o  out  axis_mosi_t  merged stream
- out_miso_i  in  axis_miso_t  downstream TREADY

## Operation
- State IDLE / LOCKED, 1-bit register. rr_ptr is a CHANNEL_NUMBER_WIDTH register. grant_q is a CHANNEL_NUMBER_WIDTH register.
- Header request: in_mosi_i[i].TVALID && in_mosi_i[i].data.TID == ROUTING_HEADER.
- IDLE behaviour:
  - Combinationally select the first requesting input i, searching rr_ptr, rr_ptr+1, … with wrap modulo CHANNEL_NUMBER.
  - The selected input is muxed to out_mosi_o. in_miso_o[i].TREADY = out_miso_i.TREADY.
  - All other in_miso_o are '0.
  - No request: out_mosi_o = '0 and every TREADY is 0.
- Header handshake (TVALID && TREADY) in IDLE:
  - TLAST=0: go to LOCKED, grant_q <= i.
  - TLAST=1 (single-flit packet): stay IDLE.
  - In both cases rr_ptr <= (i+1) mod CHANNEL_NUMBER, with wrap at CHANNEL_NUMBER-1 -> 0.
- LOCKED behaviour:
  - out_mosi_o = in_mosi_i[grant_q]. in_miso_o[grant_q].TREADY = out_miso_i.TREADY. All others are 0.
  - The TID of flits is ignored.
  - A handshake with TLAST=1 returns the block to IDLE.
- Non-header flits arriving at IDLE are never accepted (TREADY held 0). They are not granted and not dropped.
- TVALID low on the locked input mid-packet: out TVALID is 0 and the lock is held indefinitely.
- Requests from other inputs while LOCKED are stalled. Their TREADY stays 0.
- A TLAST handshake and a new header on another input in the same cycle: the new header is not granted until the following cycle, since the IDLE selection applies from the next cycle on.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, rr_ptr=0, grant_q=0.
  - Consequently out_mosi_o='0 and all in_miso_o='0 until a header request arrives.
- Zero-cycle latency. The data path and the ready path are purely combinational: in_mosi_i to out_mosi_o, and out_miso_i to in_miso_o.
- Throughput is one flit per cycle, with no bubble between header and payload.
- There is one idle arbitration cycle between back-to-back packets only when the next header comes from a different input in the TLAST cycle (see above).
- Reset asserted mid-packet abandons the lock. The next packet needs a fresh header.
- The AXI-Stream rule holds: output TVALID never depends on output TREADY.

## Structure
- axis_mosi_t, axis_miso_t and ROUTING_HEADER come from the shared axis_type.svh / package. No new typedefs are added.
- The state enum (IDLE, LOCKED) is local to the module.
- Sub-module rr_arbiter: combinational. Inputs are the request vector and the pointer. Outputs are a one-hot grant and a binary index. It is parameterized by CHANNEL_NUMBER.

## Test plan
- Single input 2 sends a 4-flit packet (header, 2 data, TLAST), out TREADY=1 -> the 4 flits appear on out_mosi_o in the same cycles, in order. Afterwards rr_ptr=3 and state=IDLE.
- Inputs 0 and 3 both present headers at reset, with rr_ptr=0 -> input 0 wins and input 3 has TREADY=0 throughout. Input 3 is then granted the cycle after input 0's TLAST, and rr_ptr=4.
- Input 4 wins, then inputs 0 and 4 both request -> input 0 wins (pointer wraps 4 -> 0) and rr_ptr becomes 1.
- Out TREADY toggled 1,0,1,0 during a locked 3-flit packet while input 1 holds a header -> no flit is lost or duplicated, and input 1 is stalled until the TLAST handshake.
- Data flit (TID≠ROUTING_HEADER) offered at IDLE on input 2 -> TREADY stays 0 and out TVALID stays 0 for 10 cycles.
- Reset pulsed mid-packet after 2 of 5 flits -> outputs are zero immediately. A continuation flit is not accepted afterwards. A new header is granted normally.
